option_menu_editor: RTL and testbench

Parametrised options-menu controller that generalises the game's option-editing logic into a standalone block: N numeric options, each with its own min, max, reset value and wrap/clamp mode, edited either by ±1 or digit-by-digit in base 10. It sits between the debounced edge-detected buttons and the game-state register. It owns the selected item, sub-edit (digit) mode and all option values. It reports changes so the render-parameter recompute runs only when a value actually moved.

---
 rtl/option_menu_editor.sv | 177 +++++++++++++++++
 tb/tb_option_menu_editor.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/option_menu_editor.sv
// Options-menu controller: item navigation, +/-1 and decimal digit editing of
// N_OPTS bounded option values, with change and exit pulses for the game FSM.
module option_menu_editor #(
   parameter int unsigned N_OPTS = 6,
   parameter int unsigned VAL_W = 8,
   parameter int unsigned DIGITS = 3,
   parameter logic [N_OPTS*VAL_W-1:0] MIN_VALS = '0,
   parameter logic [N_OPTS*VAL_W-1:0] MAX_VALS = {N_OPTS{VAL_W'(99)}},
   parameter logic [N_OPTS*VAL_W-1:0] INIT_VALS = '0,
   parameter logic [N_OPTS-1:0] ROLL_MASK = '0,
   parameter int unsigned ITEM_W = $clog2(N_OPTS+1),
   localparam int unsigned DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     START,
   input  logic                     EN,
   input  logic                     BTN_EDGE_LEFT,
   input  logic                     BTN_EDGE_RIGHT,
   input  logic                     BTN_EDGE_UP,
   input  logic                     BTN_EDGE_DOWN,
   input  logic                     BTN_EDGE_ENTER,
   input  logic                     LOAD,
   input  logic [ITEM_W-1:0]        LOAD_IDX,
   input  logic [VAL_W-1:0]         LOAD_VAL,
   output logic [ITEM_W-1:0]        SEL_ITEM,
   output logic                     IS_SUB,
   output logic [DIG_W-1:0]         SUB_DIGIT,
   output logic [N_OPTS*VAL_W-1:0]  VALUES,
   output logic                     CHANGED,
   output logic [ITEM_W-1:0]        CHANGED_IDX,
   output logic                     EXIT
);

   localparam int unsigned AW = VAL_W + 1;

   function automatic int unsigned pow10(input int unsigned e);
      int unsigned p;
      p = 1;
      for (int unsigned i = 0; i < e; i++) p = p * 10;
      return p;
   endfunction

   logic [ITEM_W-1:0] sel_q, sel_d;
   logic              sub_q, sub_d;
   logic [DIG_W-1:0]  dig_q, dig_d;
   logic [VAL_W-1:0]  vals_q [N_OPTS];
   logic [VAL_W-1:0]  vals_d [N_OPTS];
   logic              chg_q, chg_d;
   logic [ITEM_W-1:0] chg_idx_q, chg_idx_d;
   logic              exit_q, exit_d;

   logic [ITEM_W-1:0] opt_idx;
   logic              idx_ok, roll, wr_en;
   logic [VAL_W-1:0]  cur, lo, hi, wr_val, load_cl, inc1, dec1;
   logic [AW-1:0]     cur_w, lo_w, hi_w, step, add_res, sub_res;

   // Operand selection and candidate results for the addressed option
   always_comb begin
      opt_idx = LOAD ? LOAD_IDX : sel_q - 1'b1;
      idx_ok  = 1'b0;
      cur     = '0;
      lo      = '0;
      hi      = '0;
      roll    = 1'b0;
      for (int unsigned k = 0; k < N_OPTS; k++) begin
         if (opt_idx == ITEM_W'(k)) begin
            idx_ok = 1'b1;
            cur    = vals_q[k];
            lo     = MIN_VALS[k*VAL_W +: VAL_W];
            hi     = MAX_VALS[k*VAL_W +: VAL_W];
            roll   = ROLL_MASK[k];
         end
      end
      step = '0;
      for (int unsigned d = 0; d < DIGITS; d++)
         if (dig_q == DIG_W'(d)) step = AW'(pow10(DIGITS-1-d));
      cur_w = AW'(cur);
      lo_w  = AW'(lo);
      hi_w  = AW'(hi);
      // Guards keep every difference non-negative, so no wrap is possible
      add_res = (cur_w >= hi_w || step >= hi_w - cur_w) ? hi_w : cur_w + step;
      sub_res = (cur_w <= lo_w || cur_w - lo_w <= step) ? lo_w : cur_w - step;
      inc1    = (cur >= hi) ? (roll ? lo : hi) : cur + 1'b1;
      dec1    = (cur <= lo) ? (roll ? hi : lo) : cur - 1'b1;
      load_cl = (LOAD_VAL < lo) ? lo : ((LOAD_VAL > hi) ? hi : LOAD_VAL);
   end

   always_comb begin
      sel_d     = sel_q;
      sub_d     = sub_q;
      dig_d     = dig_q;
      vals_d    = vals_q;
      chg_d     = 1'b0;
      chg_idx_d = chg_idx_q;
      exit_d    = 1'b0;
      wr_en     = 1'b0;
      wr_val    = cur;
      if (LOAD) begin
         wr_en  = 1'b1;
         wr_val = load_cl;
      end else if (START) begin
         sel_d = '0;
         sub_d = 1'b0;
         dig_d = '0;
      end else if (EN) begin
         if (BTN_EDGE_ENTER) begin
            if (sel_q == '0) exit_d = 1'b1;
            else begin
               sub_d = ~sub_q;
               dig_d = '0;
            end
         end else if (BTN_EDGE_UP) begin
            if (sub_q) begin
               wr_en  = 1'b1;
               wr_val = add_res[VAL_W-1:0];
            end else if (sel_q != '0) sel_d = sel_q - 1'b1;
         end else if (BTN_EDGE_DOWN) begin
            if (sub_q) begin
               wr_en  = 1'b1;
               wr_val = sub_res[VAL_W-1:0];
            end else if (sel_q != ITEM_W'(N_OPTS)) sel_d = sel_q + 1'b1;
         end else if (BTN_EDGE_LEFT) begin
            if (sub_q) dig_d = (dig_q == '0) ? DIG_W'(DIGITS-1) : dig_q - 1'b1;
            else begin
               wr_en  = 1'b1;
               wr_val = dec1;
            end
         end else if (BTN_EDGE_RIGHT) begin
            if (sub_q) dig_d = (dig_q == DIG_W'(DIGITS-1)) ? '0 : dig_q + 1'b1;
            else begin
               wr_en  = 1'b1;
               wr_val = inc1;
            end
         end
      end
      if (wr_en && idx_ok && wr_val != cur) begin
         chg_d     = 1'b1;
         chg_idx_d = opt_idx;
         for (int unsigned k = 0; k < N_OPTS; k++)
            if (opt_idx == ITEM_W'(k)) vals_d[k] = wr_val;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         sel_q     <= '0;
         sub_q     <= 1'b0;
         dig_q     <= '0;
         chg_q     <= 1'b0;
         chg_idx_q <= '0;
         exit_q    <= 1'b0;
         for (int unsigned k = 0; k < N_OPTS; k++)
            vals_q[k] <= INIT_VALS[k*VAL_W +: VAL_W];
      end else begin
         sel_q     <= sel_d;
         sub_q     <= sub_d;
         dig_q     <= dig_d;
         chg_q     <= chg_d;
         chg_idx_q <= chg_idx_d;
         exit_q    <= exit_d;
         vals_q    <= vals_d;
      end
   end

   for (genvar g = 0; g < N_OPTS; g++) begin : g_values
      assign VALUES[g*VAL_W +: VAL_W] = vals_q[g];
   end

   assign SEL_ITEM    = sel_q;
   assign IS_SUB      = sub_q;
   assign SUB_DIGIT   = dig_q;
   assign CHANGED     = chg_q;
   assign CHANGED_IDX = chg_idx_q;
   assign EXIT        = exit_q;

endmodule

// File: tb/tb_option_menu_editor.sv
// Directed bench for option_menu_editor: navigation, +/-1 clamp and roll,
// digit editing, priority, LOAD clamping, EN gating, START and RST.
module tb_option_menu_editor;

   localparam int unsigned N_OPTS = 6;
   localparam int unsigned VAL_W  = 8;
   localparam int unsigned ITEM_W = 3;
   localparam logic [47:0] MINV  = {8'd10, 8'd0,   8'd2, 8'd0,  8'd0,  8'd2};
   localparam logic [47:0] MAXV  = {8'd200, 8'd255, 8'd8, 8'd50, 8'd99, 8'd8};
   localparam logic [47:0] INITV = {8'd100, 8'd0,   8'd6, 8'd0,  8'd5,  8'd6};

   localparam logic [5:0] L = 6'd1, R = 6'd2, U = 6'd4, D = 6'd8, E = 6'd16, S = 6'd32;

   logic CLK = 1'b0;
   logic RST, START, EN, LEFT, RIGHT, UPB, DOWNB, ENTER, LOAD;
   logic [ITEM_W-1:0] LOAD_IDX;
   logic [VAL_W-1:0]  LOAD_VAL;
   logic [ITEM_W-1:0] SEL_ITEM, CHANGED_IDX;
   logic              IS_SUB, CHANGED, EXIT;
   logic [1:0]        SUB_DIGIT;
   logic [47:0]       VALUES;
   logic [47:0]       snap;

   int checks = 0;
   int errors = 0;

   option_menu_editor #(
      .N_OPTS(N_OPTS), .VAL_W(VAL_W), .DIGITS(3),
      .MIN_VALS(MINV), .MAX_VALS(MAXV), .INIT_VALS(INITV),
      .ROLL_MASK(6'b011000)
   ) dut (
      .CLK(CLK), .RST(RST), .START(START), .EN(EN),
      .BTN_EDGE_LEFT(LEFT), .BTN_EDGE_RIGHT(RIGHT), .BTN_EDGE_UP(UPB),
      .BTN_EDGE_DOWN(DOWNB), .BTN_EDGE_ENTER(ENTER),
      .LOAD(LOAD), .LOAD_IDX(LOAD_IDX), .LOAD_VAL(LOAD_VAL),
      .SEL_ITEM(SEL_ITEM), .IS_SUB(IS_SUB), .SUB_DIGIT(SUB_DIGIT),
      .VALUES(VALUES), .CHANGED(CHANGED), .CHANGED_IDX(CHANGED_IDX), .EXIT(EXIT)
   );

   always #5 CLK = ~CLK;

   function automatic logic [7:0] ov(input int k);
      return VALUES[k*8 +: 8];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after a rising edge and are sampled at the next one
   task automatic press(input logic [5:0] m);
      {START, ENTER, DOWNB, UPB, RIGHT, LEFT} = m;
      @(posedge CLK);
      #1;
      {START, ENTER, DOWNB, UPB, RIGHT, LEFT} = '0;
      LOAD = 1'b0;
   endtask

   task automatic load(input logic [2:0] idx, input logic [7:0] v, input logic [5:0] m);
      LOAD = 1'b1;
      LOAD_IDX = idx;
      LOAD_VAL = v;
      press(m);
   endtask

   initial begin
      RST = 1'b1; EN = 1'b1; LOAD = 1'b0; LOAD_IDX = '0; LOAD_VAL = '0;
      {START, ENTER, DOWNB, UPB, RIGHT, LEFT} = '0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_sel", SEL_ITEM, 0);
      chk("rst_sub", IS_SUB, 0);
      chk("rst_dig", SUB_DIGIT, 0);
      chk("rst_vals", VALUES, INITV);
      chk("rst_chg", CHANGED, 0);
      chk("rst_chg_idx", CHANGED_IDX, 0);
      chk("rst_exit", EXIT, 0);
      RST = 1'b0;

      for (int i = 0; i < 10; i++) begin
         press(D);
         chk("nav_down", SEL_ITEM, (i < 6) ? i + 1 : 6);
         chk("nav_down_chg", CHANGED, 0);
      end
      for (int i = 0; i < 10; i++) begin
         press(U);
         chk("nav_up", SEL_ITEM, (i < 6) ? 5 - i : 0);
         chk("nav_up_chg", CHANGED, 0);
      end

      press(D);
      press(R); chk("clamp_7", ov(0), 7); chk("clamp_7_chg", CHANGED, 1); chk("clamp_7_idx", CHANGED_IDX, 0);
      press(R); chk("clamp_8", ov(0), 8); chk("clamp_8_chg", CHANGED, 1);
      press(R); chk("clamp_hold", ov(0), 8); chk("clamp_hold_chg", CHANGED, 0);

      press(D); press(D); press(D);
      chk("sel_4", SEL_ITEM, 4);
      press(R); chk("roll_7", ov(3), 7); chk("roll_7_idx", CHANGED_IDX, 3);
      press(R); chk("roll_8", ov(3), 8); chk("roll_8_chg", CHANGED, 1);
      press(R); chk("roll_wrap", ov(3), 2); chk("roll_wrap_chg", CHANGED, 1);
      press(L); chk("roll_back", ov(3), 8); chk("roll_back_chg", CHANGED, 1);

      press(U); press(U);
      press(E); chk("sub_on", IS_SUB, 1); chk("sub_dig0", SUB_DIGIT, 0);
      press(R); chk("sub_dig1", SUB_DIGIT, 1);
      press(U); chk("sub_add10", ov(1), 15); chk("sub_add10_idx", CHANGED_IDX, 1);
      press(L); chk("sub_dig_back", SUB_DIGIT, 0);
      press(U); chk("sub_add100", ov(1), 99); chk("sub_add100_chg", CHANGED, 1);
      press(U); chk("sub_sat", ov(1), 99); chk("sub_sat_chg", CHANGED, 0);
      press(R); chk("dig_r1", SUB_DIGIT, 1);
      press(R); chk("dig_r2", SUB_DIGIT, 2);
      press(R); chk("dig_rwrap", SUB_DIGIT, 0);
      press(L); chk("dig_lwrap", SUB_DIGIT, 2);
      press(R);
      press(D); chk("sub_dn_min", ov(1), 0); chk("sub_dn_min_chg", CHANGED, 1);
      press(E); chk("sub_off", IS_SUB, 0); chk("sub_off_dig", SUB_DIGIT, 0);

      press(D); press(D); press(D);
      chk("sel_5", SEL_ITEM, 5);
      press(L); chk("roll_min", ov(4), 255); chk("roll_min_idx", CHANGED_IDX, 4);
      press(E);
      press(U); chk("wide_sat", ov(4), 255); chk("wide_sat_chg", CHANGED, 0);
      press(D); chk("wide_sub", ov(4), 155); chk("wide_sub_chg", CHANGED, 1);
      press(E);

      repeat (5) press(U);
      press(E); chk("exit_hi", EXIT, 1); chk("exit_sel", SEL_ITEM, 0); chk("exit_sub", IS_SUB, 0);
      press(6'd0); chk("exit_lo", EXIT, 0);

      press(D);
      snap = VALUES;
      EN = 1'b0;
      press(L | R | U | D | E);
      chk("en_sel", SEL_ITEM, 1); chk("en_sub", IS_SUB, 0); chk("en_chg", CHANGED, 0);
      chk("en_vals", VALUES, snap);
      EN = 1'b1;

      press(D); press(D);
      press(R); chk("opt2_1", ov(2), 1);
      press(U | L); chk("prio_sel", SEL_ITEM, 2); chk("prio_val", ov(2), 1); chk("prio_chg", CHANGED, 0);

      load(3'd2, 8'd200, R);
      chk("load_clamp", ov(2), 50); chk("load_chg", CHANGED, 1); chk("load_idx", CHANGED_IDX, 2);
      chk("load_drop_r", ov(1), 0);
      load(3'd2, 8'd60, 6'd0); chk("load_eq_chg", CHANGED, 0);
      snap = VALUES;
      load(3'd6, 8'd7, 6'd0); chk("load_bad_vals", VALUES, snap); chk("load_bad_chg", CHANGED, 0);
      load(3'd5, 8'd3, 6'd0); chk("load_min", ov(5), 10); chk("load_min_idx", CHANGED_IDX, 5);

      press(E); press(R);
      snap = VALUES;
      press(S);
      chk("start_sel", SEL_ITEM, 0); chk("start_sub", IS_SUB, 0); chk("start_dig", SUB_DIGIT, 0);
      chk("start_vals", VALUES, snap);

      press(D); press(D);
      repeat (9) press(R);
      chk("nine", ov(1), 9);
      press(E);
      RST = 1'b1;
      press(U);
      RST = 1'b0;
      chk("rst2_vals", VALUES, INITV); chk("rst2_sub", IS_SUB, 0);
      chk("rst2_sel", SEL_ITEM, 0); chk("rst2_chg", CHANGED, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
